// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed 7-segment capture path: segment patterns,
// special digit codes and the frame-assembly state encoding.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111100;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1100111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam logic [3:0] DIGIT_BLANK = 4'hF;
  localparam logic [3:0] DIGIT_ERR   = 4'hE;

  typedef enum logic {
    WAIT_TEN,
    GOT_TEN
  } cap_state_t;

endpackage

// File: rtl/seg7_decode.sv
// Inverse 7-segment decode: maps a lit-segment pattern back to its BCD value,
// flagging patterns that no legal digit produces.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] value,
  output logic       is_valid
);

  always_comb begin
    value    = DIGIT_ERR;
    is_valid = 1'b1;
    case (seg)
      SEG_0:     value = 4'd0;
      SEG_1:     value = 4'd1;
      SEG_2:     value = 4'd2;
      SEG_3:     value = 4'd3;
      SEG_4:     value = 4'd4;
      SEG_5:     value = 4'd5;
      SEG_6:     value = 4'd6;
      SEG_7:     value = 4'd7;
      SEG_8:     value = 4'd8;
      SEG_9:     value = 4'd9;
      SEG_BLANK: value = DIGIT_BLANK;
      default:   is_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_capture.sv
// Receive side of the two-digit multiplexed 7-segment bus: synchronise, debounce
// each (digit, segments) pair, decode and reassemble a tens/units frame.
module seg7_capture
  import seg7_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] seg_in,
  input  logic       digit_in,
  output logic [3:0] ten_count,
  output logic [3:0] unit_count,
  output logic       valid,
  output logic       changed,
  output logic       pattern_error,
  output logic [7:0] err_count
);

  localparam int RUN_MAX = STABLE_CYCLES + 1;
  localparam int RUN_W   = $clog2(RUN_MAX + 1);
  localparam int FILL_W  = $clog2(SYNC_STAGES + 1);

  logic [7:0]        sync_pipe [SYNC_STAGES];
  logic [7:0]        pair_p0;
  logic [7:0]        pair_p1;
  logic [RUN_W-1:0]  run;
  logic [FILL_W-1:0] fill;
  logic              accept;
  logic [3:0]        dec_value;
  logic              dec_valid;
  logic [3:0]        tens_hold;
  cap_state_t        state;

  // Stage p0: synchroniser, {digit, segments} travel together
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_pipe[i] <= '0;
    end else begin
      sync_pipe[0] <= {digit_in, seg_in};
      for (int i = 1; i < SYNC_STAGES; i++) sync_pipe[i] <= sync_pipe[i-1];
    end
  end

  assign pair_p0 = sync_pipe[SYNC_STAGES-1];

  // Stage p1: run-length debounce; run describes how long pair_p1 has held.
  // The run is pinned at 0 until the synchroniser has flushed its reset zeros.
  always_ff @(posedge clk) begin
    if (reset) begin
      pair_p1 <= '0;
      run     <= '0;
      fill    <= '0;
    end else begin
      pair_p1 <= pair_p0;
      if (fill != FILL_W'(SYNC_STAGES)) begin
        fill <= fill + 1'b1;
        run  <= '0;
      end else if (pair_p0 != pair_p1) begin
        run <= RUN_W'(1);
      end else if (run != RUN_W'(RUN_MAX)) begin
        run <= run + 1'b1;
      end
    end
  end

  assign accept = (run == RUN_W'(STABLE_CYCLES));

  seg7_decode u_decode (
    .seg      (pair_p1[6:0]),
    .value    (dec_value),
    .is_valid (dec_valid)
  );

  always_ff @(posedge clk) begin
    if (accept && dec_valid && !pair_p1[7]) tens_hold <= dec_value;
  end

  // Stage p2: frame assembly and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= WAIT_TEN;
      ten_count     <= '0;
      unit_count    <= '0;
      valid         <= 1'b0;
      changed       <= 1'b0;
      pattern_error <= 1'b0;
      err_count     <= '0;
    end else begin
      valid         <= 1'b0;
      changed       <= 1'b0;
      pattern_error <= 1'b0;
      if (accept) begin
        if (!dec_valid) begin
          pattern_error <= 1'b1;
          if (err_count != 8'hFF) err_count <= err_count + 8'd1;
          state <= WAIT_TEN;
        end else begin
          case (state)
            WAIT_TEN: if (!pair_p1[7]) state <= GOT_TEN;
            GOT_TEN: begin
              if (pair_p1[7]) begin
                ten_count  <= tens_hold;
                unit_count <= dec_value;
                valid      <= 1'b1;
                changed    <= ({tens_hold, dec_value} != {ten_count, unit_count});
                state      <= WAIT_TEN;
              end
            end
            default: state <= WAIT_TEN;
          endcase
        end
      end
    end
  end

endmodule
